// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states and
// the signed add/sub overflow rule.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NE   = 4'b0011;
  localparam logic [3:0] OP_EQ   = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_NOR  = 4'b1110;
  localparam logic [3:0] OP_RSV  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Signed overflow from operand and result sign bits; for subtraction the
  // operand signs must differ, for addition they must match.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb, input logic is_sub);
    logic ovf;
    if (is_sub) begin
      ovf = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      ovf = (a_msb == b_msb) && (r_msb != a_msb);
    end
    return ovf;
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of the multi-cycle ALU: a valid/ready request
// channel carrying operands and opcode, and a valid/ready result channel.
interface alu_mc_if #(parameter int WIDTH = 32);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             ovf_o;

  modport slave (
    input  valid_i, src1_i, src2_i, ctrl_i, ready_i,
    output ready_o, valid_o, result_o, zero_o, ovf_o
  );

  modport master (
    output valid_i, src1_i, src2_i, ctrl_i, ready_i,
    input  ready_o, valid_o, result_o, zero_o, ovf_o
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles
// after start; done/product are combinational in the final iteration cycle.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [WIDTH-1:0] acc_next_s;
  logic             last_s;

  // Partial-product accumulate for the current multiplier bit
  always_comb begin
    acc_next_s = acc_r;
    if (b_r[0]) begin
      acc_next_s = acc_r + a_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  assign last_s  = busy_r && (cnt_r == CNT_W'(WIDTH - 1));
  assign done    = last_s;
  assign product = acc_next_s;

  // Operand capture at start, then one shift-add step per cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_r  <= '0;
      a_r    <= '0;
      b_r    <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (start) begin
      acc_r  <= '0;
      a_r    <= mcand;
      b_r    <= mplier;
      cnt_r  <= '0;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      acc_r  <= acc_next_s;
      a_r    <= a_r << 1;
      b_r    <= b_r >> 1;
      cnt_r  <= cnt_r + CNT_W'(1);
      busy_r <= !last_s;
    end else begin
      acc_r  <= acc_r;
      a_r    <= a_r;
      b_r    <= b_r;
      cnt_r  <= cnt_r;
      busy_r <= busy_r;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops plus an
// iterative multiply, sequenced by an IDLE/MUL/DONE handshake FSM.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk_i,
  input logic     rst_i,
  alu_mc_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int HALF    = WIDTH / 2;

  state_e             state_r;
  state_e             state_next_s;
  logic               ready_r;
  logic               valid_r;
  logic               zero_r;
  logic               ovf_r;
  logic [WIDTH-1:0]   result_r;

  logic [WIDTH-1:0]   a_s;
  logic [WIDTH-1:0]   b_s;
  logic [3:0]         op_s;
  logic [WIDTH-1:0]   sum_s;
  logic [WIDTH-1:0]   diff_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_ovf_s;
  logic               accept_s;
  logic               mul_start_s;
  logic               mul_done_s;
  logic [WIDTH-1:0]   mul_prod_s;

  assign a_s     = bus.src1_i;
  assign b_s     = bus.src2_i;
  assign op_s    = bus.ctrl_i;
  assign sum_s   = a_s + b_s;
  assign diff_s  = a_s - b_s;
  assign shamt_s = a_s[SHAMT_W-1:0];

  // Single-cycle datapath; MUL and the reserved code yield zero here
  always_comb begin
    alu_res_s = '0;
    alu_ovf_s = 1'b0;
    case (op_s)
      OP_AND:  alu_res_s = a_s & b_s;
      OP_OR:   alu_res_s = a_s | b_s;
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum_s[WIDTH-1], 1'b0);
      end
      OP_NE:   alu_res_s = {{(WIDTH-1){1'b0}}, (a_s != b_s)};
      OP_EQ:   alu_res_s = {{(WIDTH-1){1'b0}}, (a_s == b_s)};
      OP_LUI:  alu_res_s = b_s << HALF;
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], diff_s[WIDTH-1], 1'b1);
      end
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
      OP_SRA:  alu_res_s = $unsigned($signed(b_s) >>> shamt_s);
      OP_SRL:  alu_res_s = b_s >> shamt_s;
      OP_SLL:  alu_res_s = b_s << shamt_s;
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_XOR:  alu_res_s = a_s ^ b_s;
      OP_NOR:  alu_res_s = ~(a_s | b_s);
      default: alu_res_s = '0;
    endcase
  end

  // Next-state and accept decode
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    mul_start_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.valid_i && ready_r) begin
          accept_s = 1'b1;
          if (op_s == OP_MUL) begin
            mul_start_s  = 1'b1;
            state_next_s = ST_MUL;
          end else begin
            state_next_s = ST_DONE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_MUL;
        end
      end
      ST_DONE: begin
        if (bus.ready_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, handshake flags and result registers; flags derive from the
  // next state so they switch on the same edge as the FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      result_r <= '0;
      zero_r   <= 1'b1;
      ovf_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == ST_IDLE);
      valid_r <= (state_next_s == ST_DONE);
      if (accept_s && !mul_start_s) begin
        result_r <= alu_res_s;
        zero_r   <= (alu_res_s == '0);
        ovf_r    <= alu_ovf_s;
      end else if ((state_r == ST_MUL) && mul_done_s) begin
        result_r <= mul_prod_s;
        zero_r   <= (mul_prod_s == '0);
        ovf_r    <= 1'b0;
      end else begin
        result_r <= result_r;
        zero_r   <= zero_r;
        ovf_r    <= ovf_r;
      end
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (mul_start_s),
    .mcand   (a_s),
    .mplier  (b_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  assign bus.ready_o  = ready_r;
  assign bus.valid_o  = valid_r;
  assign bus.result_o = result_r;
  assign bus.zero_o   = zero_r;
  assign bus.ovf_o    = ovf_r;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=32 and WIDTH=8: directed vector table, handshake
// and reset corner sequences, and random ops against an arithmetic model.
module tb_alu_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32)) b32();
  alu_mc_if #(.WIDTH(8))  b8();

  alu_mc #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(b32));
  alu_mc #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(b8));

  typedef struct {
    bit          w8;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic at width w
  function automatic void ref_model(input int w, input logic [3:0] op,
                                    input logic [63:0] a_in, input logic [63:0] b_in,
                                    output logic [63:0] res, output logic ovf, output int lat);
    logic [63:0] mask, a, b;
    longint sa, sb, full, smax, smin;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    sh = int'(a & 64'(w - 1));
    ovf = 1'b0;
    full = 0;
    case (op)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  begin full = sa + sb; res = (a + b) & mask; ovf = (full > smax) || (full < smin); end
      4'd3:  res = (a != b) ? 64'd1 : 64'd0;
      4'd4:  res = (a == b) ? 64'd1 : 64'd0;
      4'd5:  res = (b << (w / 2)) & mask;
      4'd6:  begin full = sa - sb; res = (a - b) & mask; ovf = (full > smax) || (full < smin); end
      4'd7:  res = (sa < sb) ? 64'd1 : 64'd0;
      4'd8:  res = 64'(sb >>> sh) & mask;
      4'd9:  res = b >> sh;
      4'd10: res = (b << sh) & mask;
      4'd11: res = (a < b) ? 64'd1 : 64'd0;
      4'd12: res = (a * b) & mask;
      4'd13: res = a ^ b;
      4'd14: res = ~(a | b) & mask;
      default: res = 64'd0;
    endcase
    lat = (op == 4'd12) ? w + 1 : 1;
  endfunction

  task automatic drive(input bit w8, input logic v, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      b8.valid_i = v; b8.ctrl_i = op; b8.src1_i = a[7:0]; b8.src2_i = b[7:0];
    end else begin
      b32.valid_i = v; b32.ctrl_i = op; b32.src1_i = a[31:0]; b32.src2_i = b[31:0];
    end
  endtask

  task automatic sample(input bit w8, output logic vo, output logic ro,
                        output logic [63:0] r, output logic z, output logic o);
    if (w8) begin
      vo = b8.valid_o; ro = b8.ready_o; r = {56'd0, b8.result_o}; z = b8.zero_o; o = b8.ovf_o;
    end else begin
      vo = b32.valid_o; ro = b32.ready_o; r = {32'd0, b32.result_o}; z = b32.zero_o; o = b32.ovf_o;
    end
  endtask

  // One request/response; inputs are scrambled while the op is in flight
  task automatic xact(input bit w8, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      output logic [63:0] r, output logic z, output logic o,
                      output int lat, output bit busy_ok);
    logic vo, ro;
    int n;
    busy_ok = 1'b1;
    n = 0;
    sample(w8, vo, ro, r, z, o);
    while (!ro && n < 100) begin
      @(negedge clk); sample(w8, vo, ro, r, z, o); n++;
    end
    drive(w8, 1'b1, op, a, b);
    @(negedge clk);
    lat = 1;
    sample(w8, vo, ro, r, z, o);
    while (!vo && lat < 200) begin
      if (ro) busy_ok = 1'b0;
      drive(w8, 1'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      @(negedge clk);
      lat++;
      sample(w8, vo, ro, r, z, o);
    end
    drive(w8, 1'b0, op, a, b);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [63:0] r; logic z, o; int lat; bit busy_ok;
    xact(v.w8, v.op, v.a, v.b, r, z, o, lat, busy_ok);
    check({tag, "_result"}, r, v.res);
    check({tag, "_zero"}, 64'(z), 64'(v.z));
    check({tag, "_ovf"}, 64'(o), 64'(v.o));
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    check({tag, "_busy_ready_low"}, 64'(busy_ok), 64'd1);
  endtask

  function automatic void add_vec(input bit w8, input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic [63:0] res,
                                  input logic z, input logic o, input int lat);
    vec_t v;
    v.w8 = w8; v.op = op; v.a = a; v.b = b; v.res = res; v.z = z; v.o = o; v.lat = lat;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [63:0] r, er; logic z, o, eo, vo, ro; int lat, elat, seen; bit busy_ok;
    logic [3:0] op; logic [63:0] a, b;

    add_vec(0, 4'd2,  64'h7FFF_FFFF, 64'h1,         64'h8000_0000, 1'b0, 1'b1, 1);
    add_vec(0, 4'd6,  64'h5,         64'h5,         64'h0,         1'b1, 1'b0, 1);
    add_vec(0, 4'd7,  64'hFFFF_FFFF, 64'h1,         64'h1,         1'b0, 1'b0, 1);
    add_vec(0, 4'd11, 64'hFFFF_FFFF, 64'h1,         64'h0,         1'b1, 1'b0, 1);
    add_vec(0, 4'd8,  64'h24,        64'h8000_0000, 64'hF800_0000, 1'b0, 1'b0, 1);
    add_vec(0, 4'd9,  64'h24,        64'h8000_0000, 64'h0800_0000, 1'b0, 1'b0, 1);
    add_vec(0, 4'd10, 64'h24,        64'h1,         64'h10,        1'b0, 1'b0, 1);
    add_vec(0, 4'd12, 64'hFFFF_FFFF, 64'h3,         64'hFFFF_FFFD, 1'b0, 1'b0, 33);
    add_vec(0, 4'd12, 64'h8000_0000, 64'h8000_0000, 64'h0,         1'b1, 1'b0, 33);
    add_vec(0, 4'd15, 64'h1234,      64'h5678,      64'h0,         1'b1, 1'b0, 1);
    add_vec(0, 4'd5,  64'h0,         64'h1234,      64'h1234_0000, 1'b0, 1'b0, 1);
    add_vec(0, 4'd3,  64'h3,         64'h3,         64'h0,         1'b1, 1'b0, 1);
    add_vec(0, 4'd4,  64'h3,         64'h3,         64'h1,         1'b0, 1'b0, 1);
    add_vec(0, 4'd6,  64'h8000_0000, 64'h1,         64'h7FFF_FFFF, 1'b0, 1'b1, 1);
    add_vec(0, 4'd14, 64'h0,         64'h0,         64'hFFFF_FFFF, 1'b0, 1'b0, 1);
    add_vec(1, 4'd2,  64'h7F,        64'h1,         64'h80,        1'b0, 1'b1, 1);
    add_vec(1, 4'd12, 64'hFF,        64'h3,         64'hFD,        1'b0, 1'b0, 9);
    add_vec(1, 4'd8,  64'h0B,        64'h80,        64'hF0,        1'b0, 1'b0, 1);

    drive(0, 1'b0, 4'd0, 64'd0, 64'd0);
    drive(1, 1'b0, 4'd0, 64'd0, 64'd0);
    b32.ready_i = 1'b1;
    b8.ready_i  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    sample(0, vo, ro, r, z, o);
    check("rst32_valid", 64'(vo), 64'd0);
    check("rst32_ready", 64'(ro), 64'd1);
    check("rst32_result", r, 64'd0);
    check("rst32_zero", 64'(z), 64'd1);
    check("rst32_ovf", 64'(o), 64'd0);
    sample(1, vo, ro, r, z, o);
    check("rst8_ready", 64'(ro), 64'd1);
    check("rst8_zero", 64'(z), 64'd1);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Result held while the consumer stalls, released on ready_i
    drive(0, 1'b1, 4'd2, 64'd10, 64'd20);
    b32.ready_i = 1'b0;
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 64'd0, 64'd0);
    for (int k = 0; k < 5; k++) begin
      sample(0, vo, ro, r, z, o);
      check("stall_valid", 64'(vo), 64'd1);
      check("stall_result", r, 64'd30);
      @(negedge clk);
    end
    b32.ready_i = 1'b1;
    @(negedge clk);
    sample(0, vo, ro, r, z, o);
    check("release_valid", 64'(vo), 64'd0);
    check("release_ready", 64'(ro), 64'd1);

    // Reset in the tenth MUL cycle discards the op
    drive(0, 1'b1, 4'd12, 64'h1234_5678, 64'h9);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 64'd0, 64'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample(0, vo, ro, r, z, o);
    check("midrst_ready", 64'(ro), 64'd1);
    check("midrst_result", r, 64'd0);
    check("midrst_zero", 64'(z), 64'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      sample(0, vo, ro, r, z, o);
      if (vo) seen++;
      @(negedge clk);
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    xact(0, 4'd2, 64'd2, 64'd3, r, z, o, lat, busy_ok);
    check("post_rst_add", r, 64'd5);

    // Random ops against the model at both widths
    for (int k = 0; k < 160; k++) begin
      bit w8;
      w8 = (k >= 110);
      op = 4'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = w8 ? 64'h80 : 64'h8000_0000;
      if ($urandom_range(0, 3) == 0) b = a;
      ref_model(w8 ? 8 : 32, op, a, b, er, eo, elat);
      xact(w8, op, a, b, r, z, o, lat, busy_ok);
      check($sformatf("rnd%0d_op%0d_result", k, op), r, er);
      check($sformatf("rnd%0d_zero", k), 64'(z), 64'(er == 64'd0));
      check($sformatf("rnd%0d_ovf", k), 64'(o), 64'(eo));
      check($sformatf("rnd%0d_latency", k), 64'(lat), 64'(elat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
